piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the Mealy sequence-detector FSM.
- Accepts DATA_W-bit words on a valid/ready handshake and drives them out one bit per enabled clock.
- ser_o connects directly to the FSM's mealy_i; ser_valid_o qualifies the stream for the bench and the scoreboard.
- Supports back-to-back words with no idle bubble, so the downstream FSM sees a continuous bit stream across word boundaries.

Parameters:
- DATA_W, 8, width of parallel input word; legal range 2..32.
- MSB_FIRST, 1, 1 = shift out bit DATA_W-1 first; 0 = shift out bit 0 first.

Ports:
- clk_i  input  1  single system clock; all logic on its rising edge.
- rst_i  input  1  synchronous reset, active-high.
- data_i  input  DATA_W  parallel word to serialize.
- valid_i  input  1  data_i valid.
- ready_o  output  1  block can accept a word this cycle.
- en_i  input  1  shift enable (bit-rate pacing); bits advance only on edges where en_i=1.
- ser_o  output  1  serial bit, registered; drives the FSM's mealy_i.
- ser_valid_o  output  1  ser_o carries a live bit.
- done_o  output  1  one-cycle pulse on the edge that retires the last bit of a word.

Behaviour:
- Interface: one clock, clk_i. rst_i is synchronous and active-high.
- Reset: while rst_i=1 at a rising edge, the block enters IDLE and clears:
  - ser_o=0, ser_valid_o=0, done_o=0, shift register=0, bit counter=0.
  - ready_o is forced 0 during any cycle in which rst_i=1.
  - Reset mid-word discards the word; no done_o pulse.
- State machine:
  - IDLE: ser_valid_o=0, ser_o=0, ready_o=1.
  - SHIFT: ser_valid_o=1.
- Accept:
  - A word is accepted on a rising edge where valid_i=1 and ready_o=1.
  - The shift register loads data_i, the bit counter loads 0, the state becomes SHIFT.
  - The first bit appears on ser_o in the cycle after the accept edge (latency 1).
- Shift:
  - In SHIFT, on each edge with en_i=1, the counter increments and the next bit is presented.
  - With en_i=0, all state holds and ser_o is stable.
  - Bit order follows MSB_FIRST.
- Last bit: the cycle where counter = N-1 and en_i=1, with N = DATA_W (N = DATA_W+1 with parity; see Optional Feature).
  - On that edge done_o pulses high for exactly one cycle.
  - If valid_i=1 on that edge, the next word loads and its first bit follows with no gap.
  - Otherwise the state returns to IDLE.
- ready_o timing:
  - ready_o = IDLE, or (SHIFT and last-bit cycle and en_i=1). It is combinational from state, counter and en_i.
  - ready_o does not depend on valid_i.
- Input stability: data_i is sampled only on the accept edge. Changes to data_i at any other time have no effect.
- valid_i with ready_o=0: the word is not taken. The upstream source must hold it; there is no internal buffering.
- Counter width: $clog2(DATA_W+2) bits. It never wraps past N-1.
- X-safety: outputs are never X after the first reset edge.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all DATA_W bits, computed at accept) is appended as bit N-1 = DATA_W, after the data bits.
  - A word occupies DATA_W+1 enabled cycles; done_o pulses on the parity bit.
  - The parity bit is a full live bit, with ser_valid_o=1.
- Not defined: no parity bit; a word occupies exactly DATA_W enabled cycles. No parity logic is synthesized.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with valid_i=1 -> ready_o=0, ser_o=0, ser_valid_o=0, done_o=0. Release -> ready_o=1 next cycle.
- Single word: DATA_W=8, MSB_FIRST=1, en_i=1, send 8'hA5.
  - ser_o = 1,0,1,0,0,1,0,1 on cycles 1..8 after accept, with ser_valid_o=1 throughout.
  - done_o pulses on cycle 8; state returns to IDLE and ser_valid_o=0 on cycle 9.
- Back-to-back: 8'hA5 then 8'h0F, valid_i held high.
  - 16 contiguous bits 1010_0101_0000_1111 with no ser_valid_o gap.
  - Two done_o pulses, 8 cycles apart.
  - ready_o is high only on the accept cycles.
- Pacing: 8'hC3 with en_i toggling 1,0,1,0,...
  - Each bit is held 2 cycles; the sequence is still 1,1,0,0,0,0,1,1.
  - done_o pulses once, 16 cycles after accept.
- Reset mid-word: send 8'hFF, assert rst_i after 3 bits -> next cycle ser_o=0, ser_valid_o=0, no done_o pulse. A fresh 8'h55 then serializes correctly.
- Parity (SERIALIZER_PARITY_EN defined): send 8'h07 -> bits 0,0,0,0,0,1,1,1 then parity 1. done_o pulses on bit 9. With MSB_FIRST=0, 8'h07 -> 1,1,1,0,0,0,0,0, then 1.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding the Mealy sequence detector.
// Optional even-parity trailer bit: define SERIALIZER_PARITY_EN.
module piso_serializer #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              en_i,
    output logic              ser_o,
    output logic              ser_valid_o,
    output logic              done_o
);

`ifdef SERIALIZER_PARITY_EN
    localparam int N = DATA_W + 1;
`else
    localparam int N = DATA_W;
`endif
    localparam int CW = $clog2(DATA_W + 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state;
    logic [N-1:0]   sr;
    logic [CW-1:0]  cnt;
    logic           last_bit;
    logic           accept;
    logic [N-1:0]   load_vec;
    logic [N-1:0]   shifted;

    function automatic logic first_bit(input logic [N-1:0] v);
        return MSB_FIRST ? v[N-1] : v[0];
    endfunction

    // Parity sits after the data bits in shift order, so its position depends on direction.
`ifdef SERIALIZER_PARITY_EN
    assign load_vec = MSB_FIRST ? {data_i, ^data_i} : {^data_i, data_i};
`else
    assign load_vec = data_i;
`endif

    assign shifted  = MSB_FIRST ? (sr << 1) : (sr >> 1);
    assign last_bit = (state == SHIFT) && (cnt == CW'(N - 1)) && en_i;
    assign ready_o  = !rst_i && ((state == IDLE) || last_bit);
    assign accept   = valid_i && ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            ser_o       <= 1'b0;
            ser_valid_o <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= last_bit;
            if (accept) begin
                // Also covers the back-to-back reload on the last-bit edge.
                state       <= SHIFT;
                sr          <= load_vec;
                cnt         <= '0;
                ser_o       <= first_bit(load_vec);
                ser_valid_o <= 1'b1;
            end else if (last_bit) begin
                state       <= IDLE;
                sr          <= '0;
                cnt         <= '0;
                ser_o       <= 1'b0;
                ser_valid_o <= 1'b0;
            end else if ((state == SHIFT) && en_i) begin
                sr    <= shifted;
                cnt   <= cnt + CW'(1);
                ser_o <= first_bit(shifted);
            end
        end
    end

endmodule
